inf_neuron_sequencer: RTL and testbench

Control-side counterpart of the sequential integrate-no-fire accumulator neuron. It time-multiplexes one accumulator neuron across `N_OUT` output neurons. For each output neuron it drives the neuron's load / accumulate / output strobes, streams weights from a synchronous weight ROM gated by a latched input spike vector, and captures each resulting membrane voltage into a result stream. It sits between the layer's spike source and the readout/argmax logic, with the accumulator neuron instance on its side channel.

---
 rtl/inf_neuron_sequencer.sv | 176 +++++++++++++++++
 tb/tb_inf_neuron_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inf_neuron_sequencer.sv
// ---------------------------------------------------------------------------
// inf_neuron_sequencer
//
// Time-multiplexes one integrate-no-fire accumulator neuron across N_OUT
// output neurons. For each output neuron j it loads the neuron with the
// latched initial membrane value, streams N_IN weights from a synchronous
// weight ROM (address j*N_IN+i), gated by the latched spike vector, fires the
// neuron and captures the resulting membrane voltage into a result stream.
//
// Build option:
//   SKIP_ZERO_SPIKE_EN  when defined, the ROM read strobe is raised only for
//                       inputs whose spike bit is set. Addresses, strobes to
//                       the neuron and all cycle timing are unchanged.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                run request (accepted only when idle)
//   spike_vec            input spikes, latched on accepted start
//   init_mem_vol         initial membrane value, latched on accepted start
//   busy, done           run status / one-cycle end-of-run pulse
//   w_rd_en, w_addr      weight ROM read strobe and address
//   w_data               ROM data, one cycle after w_rd_en
//   nrn_*                neuron side channel (weight, init value, strobes)
//   nrn_mem_vol          neuron membrane output
//   res_valid, res_idx,
//   res_mem_vol          result stream, one pulse per output neuron
// ---------------------------------------------------------------------------
module inf_neuron_sequencer #(
  parameter int N_IN   = 20,
  parameter int N_OUT  = 18,
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_IN-1:0]   spike_vec,
  input  logic [15:0]       init_mem_vol,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [7:0]        w_data,
  output logic [7:0]        nrn_weight,
  output logic [15:0]       nrn_input_mem_vol,
  output logic              nrn_load_en,
  output logic              nrn_input_valid,
  output logic              nrn_output_en,
  input  logic [15:0]       nrn_mem_vol,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [15:0]       res_mem_vol
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0]     I_LAST = IW'(N_IN - 1);
  localparam logic [IDX_W-1:0]  J_LAST = IDX_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(N_IN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FIRE, S_CAPTURE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]     i_cnt;
  logic [IDX_W-1:0]  j_cnt;
  logic [ADDR_W-1:0] base;
  logic [N_IN-1:0]   spike_lat;
  logic [15:0]       init_lat;
  logic              vld_p1;
  logic              spk_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Issue stage (p0) -> data-return stage (p1): the ROM answers one cycle
  // after the address, so the pending flag and the spike bit of the issued
  // input travel one cycle to line up with w_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      base      <= '0;
      spike_lat <= '0;
      init_lat  <= '0;
      vld_p1    <= 1'b0;
      spk_p1    <= 1'b0;
    end else begin
      vld_p1 <= (state == S_STREAM);
      spk_p1 <= (state == S_STREAM) & spike_lat[i_cnt];
      case (state)
        S_IDLE: begin
          if (start) begin
            spike_lat <= spike_vec;
            init_lat  <= init_mem_vol;
            i_cnt     <= '0;
            j_cnt     <= '0;
            base      <= '0;
          end
        end
        S_STREAM: i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
        S_CAPTURE: begin
          // Running base replaces j*N_IN.
          base  <= base + BASE_STEP;
          j_cnt <= j_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    w_rd_en       = 1'b0;
    w_addr        = '0;
    nrn_load_en   = 1'b0;
    nrn_output_en = 1'b0;
    res_valid     = 1'b0;
    res_idx       = '0;
    res_mem_vol   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        nrn_load_en = 1'b1;
        state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        busy   = 1'b1;
`ifdef SKIP_ZERO_SPIKE_EN
        w_rd_en = spike_lat[i_cnt];
`else
        w_rd_en = 1'b1;
`endif
        w_addr = base + ADDR_W'(i_cnt);
        if (i_cnt == I_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_FIRE;
      end
      S_FIRE: begin
        busy          = 1'b1;
        nrn_output_en = 1'b1;
        state_nxt     = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy        = 1'b1;
        res_valid   = 1'b1;
        res_idx     = j_cnt;
        res_mem_vol = nrn_mem_vol;
        state_nxt   = (j_cnt == J_LAST) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Only the issue of a spiking input produces an accumulate strobe, and the
  // weight is forced to zero outside those cycles so idle outputs stay quiet.
  assign nrn_input_valid   = vld_p1 & spk_p1;
  assign nrn_weight        = nrn_input_valid ? w_data : 8'd0;
  assign nrn_input_mem_vol = init_lat;

endmodule

// File: tb/tb_inf_neuron_sequencer.sv
`timescale 1ns/1ps
module tb_inf_neuron_sequencer;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 2;
  localparam int ADDR_W  = 3;
  localparam int IDX_W   = 1;
  localparam int PER     = N_IN + 4;
  localparam int RUN_LEN = N_OUT * PER;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N_IN-1:0]   spike_vec;
  logic [15:0]       init_mem_vol;
  logic              busy, done, w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data = 8'd0;
  logic [7:0]        nrn_weight;
  logic [15:0]       nrn_input_mem_vol;
  logic              nrn_load_en, nrn_input_valid, nrn_output_en;
  logic [15:0]       nrn_mem_vol = 16'd0;
  logic              res_valid;
  logic [IDX_W-1:0]  res_idx;
  logic [15:0]       res_mem_vol;

  inf_neuron_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_vec(spike_vec),
    .init_mem_vol(init_mem_vol), .busy(busy), .done(done), .w_rd_en(w_rd_en),
    .w_addr(w_addr), .w_data(w_data), .nrn_weight(nrn_weight),
    .nrn_input_mem_vol(nrn_input_mem_vol), .nrn_load_en(nrn_load_en),
    .nrn_input_valid(nrn_input_valid), .nrn_output_en(nrn_output_en),
    .nrn_mem_vol(nrn_mem_vol), .res_valid(res_valid), .res_idx(res_idx),
    .res_mem_vol(res_mem_vol)
  );

  always #5 clk = ~clk;

  // Weight ROM w[k] = k+1, one-cycle read latency.
  always @(posedge clk) if (w_rd_en) w_data <= {5'd0, w_addr} + 8'd1;

  // Accumulator neuron.
  logic [15:0] acc = 16'd0;
  always @(posedge clk) begin
    if (nrn_load_en) acc <= nrn_input_mem_vol;
    else if (nrn_input_valid) acc <= acc + {8'd0, nrn_weight};
    else if (nrn_output_en) begin
      nrn_mem_vol <= acc;
      acc <= 16'd0;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is "active" for RUN_LEN+1 cycles after start is
  // accepted; m_o is the cycle offset within the run (0 = first busy cycle).
  bit              m_act = 1'b0;
  int              m_o = 0;
  logic [N_IN-1:0] m_spk = '0;
  logic [15:0]     m_init = 16'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_init <= 16'd0;
      m_spk  <= '0;
    end else if (!m_act) begin
      if (start) begin
        m_act  <= 1'b1;
        m_o    <= 0;
        m_spk  <= spike_vec;
        m_init <= init_mem_vol;
      end
    end else if (m_o == RUN_LEN) m_act <= 1'b0;
    else m_o <= m_o + 1;
  end

  function automatic logic [15:0] exp_vol(input int j);
    int s;
    s = int'(m_init);
    for (int i = 0; i < N_IN; i++) if (m_spk[i]) s += j * N_IN + i + 1;
    return 16'(s);
  endfunction

  bit chk_en = 1'b0;
  int rd_cnt = 0, iv_cnt = 0, done_cnt = 0;
  logic [15:0] res_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      int j, p;
      logic e_ld, e_rd, e_iv, e_oe, e_rv;
      logic [31:0] e_addr, e_wt, e_idx, e_vol;
      e_ld = 0; e_rd = 0; e_iv = 0; e_oe = 0; e_rv = 0;
      e_addr = 0; e_wt = 0; e_idx = 0; e_vol = 0;
      j = 0; p = 0;
      if (m_act && m_o < RUN_LEN) begin
        j = m_o / PER;
        p = m_o % PER;
        e_ld = (p == 0);
        if (p >= 1 && p <= N_IN) begin
          e_addr = j * N_IN + p - 1;
`ifdef SKIP_ZERO_SPIKE_EN
          e_rd = m_spk[p-1];
`else
          e_rd = 1'b1;
`endif
        end
        if (p >= 2 && p <= N_IN + 1 && m_spk[p-2]) begin
          e_iv = 1'b1;
          e_wt = j * N_IN + (p - 2) + 1;
        end
        e_oe = (p == N_IN + 2);
        if (p == N_IN + 3) begin
          e_rv = 1'b1;
          e_idx = j;
          e_vol = exp_vol(j);
        end
      end
      chk("busy", busy, m_act);
      chk("done", done, m_act && m_o == RUN_LEN);
      chk("load_en", nrn_load_en, e_ld);
      chk("w_rd_en", w_rd_en, e_rd);
      chk("w_addr", w_addr, e_addr);
      chk("input_valid", nrn_input_valid, e_iv);
      chk("weight", nrn_weight, e_wt);
      chk("output_en", nrn_output_en, e_oe);
      chk("res_valid", res_valid, e_rv);
      chk("res_idx", res_idx, e_idx);
      chk("res_mem_vol", res_mem_vol, e_vol);
      chk("init_vol", nrn_input_mem_vol, m_init);
      if (w_rd_en) rd_cnt++;
      if (nrn_input_valid) iv_cnt++;
      if (done) done_cnt++;
      if (res_valid) res_log.push_back(res_mem_vol);
    end
  end

  task automatic do_start(input logic [N_IN-1:0] sv, input logic [15:0] iv, output time t0);
    @(posedge clk); #1;
    spike_vec = sv; init_mem_vol = iv; start = 1'b1;
    @(posedge clk); t0 = $time; #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input time t0, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) chk(nm, 0, 1);
    else chk(nm, int'(($time - t0 - 5) / 10), RUN_LEN);
  endtask

  task automatic chk_res(input int b, input string nm, input int e0, input int e1);
    chk({nm, "_n"}, res_log.size() - b, 2);
    if (res_log.size() - b >= 2) begin
      chk({nm, "_r0"}, res_log[b], e0);
      chk({nm, "_r1"}, res_log[b+1], e1);
    end
  endtask

  initial begin
    time t0;
    int b, c0, c1;
    rst_n = 1'b0; start = 1'b0; spike_vec = '0; init_mem_vol = 16'd0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd", w_rd_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // All spikes on.
    b = res_log.size(); c0 = rd_cnt; c1 = iv_cnt;
    do_start(4'b1111, 16'd0, t0);
    wait_done(t0, "A_done_lat");
    chk_res(b, "A", 10, 26);
    chk("A_rd_cnt", rd_cnt - c0, 8);
    chk("A_iv_cnt", iv_cnt - c1, 8);
    repeat (3) @(posedge clk);

    // Alternate spikes.
    b = res_log.size(); c0 = rd_cnt;
    do_start(4'b0101, 16'd0, t0);
    wait_done(t0, "B_done_lat");
    chk_res(b, "B", 4, 12);
`ifdef SKIP_ZERO_SPIKE_EN
    chk("B_rd_cnt", rd_cnt - c0, 4);
`else
    chk("B_rd_cnt", rd_cnt - c0, 8);
`endif
    repeat (3) @(posedge clk);

    // No spikes, nonzero init.
    b = res_log.size(); c1 = iv_cnt;
    do_start(4'b0000, 16'd100, t0);
    wait_done(t0, "C_done_lat");
    chk_res(b, "C", 100, 100);
    chk("C_iv_cnt", iv_cnt - c1, 0);
    repeat (3) @(posedge clk);

    // Extra start pulse mid-run is ignored.
    b = res_log.size(); c0 = done_cnt;
    do_start(4'b1111, 16'd0, t0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(t0, "D_done_lat");
    repeat (20) @(negedge clk);
    chk("D_done_cnt", done_cnt - c0, 1);
    chk_res(b, "D", 10, 26);

    // Start held: one IDLE cycle between runs.
    b = res_log.size();
    @(posedge clk); #1 spike_vec = 4'b1111; init_mem_vol = 16'd0; start = 1'b1;
    @(posedge clk); t0 = $time;
    wait_done(t0, "E_done_lat1");
    @(negedge clk);
    chk("E_idle_gap", busy, 0);
    @(negedge clk);
    chk("E_reload", nrn_load_en, 1);
    t0 = $time - 5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(t0, "E_done_lat2");
    chk("E_nres", res_log.size() - b, 4);
    repeat (3) @(posedge clk);

    // Reset during STREAM of neuron 0.
    b = res_log.size(); c0 = done_cnt;
    do_start(4'b1111, 16'd0, t0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("F_busy", busy, 0);
    chk("F_rd", w_rd_en, 0);
    chk("F_init", nrn_input_mem_vol, 0);
    repeat (30) @(negedge clk);
    chk("F_nres", res_log.size() - b, 0);
    chk("F_ndone", done_cnt - c0, 0);
    b = res_log.size();
    do_start(4'b1111, 16'd0, t0);
    wait_done(t0, "F_done_lat");
    chk_res(b, "F", 10, 26);
    repeat (3) @(posedge clk);

    // Inputs change after acceptance.
    b = res_log.size();
    do_start(4'b1111, 16'd0, t0);
    spike_vec = 4'b0000; init_mem_vol = 16'd555;
    wait_done(t0, "G_done_lat");
    chk_res(b, "G", 10, 26);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
